// File: rtl/debug_run_ctrl_if.sv
// Host command channel of the debug run controller: one command per valid cycle,
// always ready, with a one-cycle rejection pulse back to the host.
interface debug_run_ctrl_if #(
  parameter int ARG_WIDTH = 16
);
  logic                 i_cmdValid;
  logic [2:0]           i_cmdOp;
  logic [ARG_WIDTH-1:0] i_cmdArg;
  logic                 o_cmdReady;
  logic                 o_cmdError;

  modport master (
    output i_cmdValid, i_cmdOp, i_cmdArg,
    input  o_cmdReady, o_cmdError
  );

  modport slave (
    input  i_cmdValid, i_cmdOp, i_cmdArg,
    output o_cmdReady, o_cmdError
  );
endinterface

// File: rtl/debug_run_ctrl.sv
// Run/step/breakpoint controller driving the registered CPU halt line, with a
// halt event (cause + PC) reported for every transition into HALTED.
module debug_run_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16,
  parameter int CYC_WIDTH   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  debug_run_ctrl_if.slave       cmd,
  input  logic                  i_instrFinished,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  output logic                  o_halt,
  output logic [1:0]            o_state,
  output logic                  o_evtValid,
  output logic [1:0]            o_evtCause,
  output logic [ADDR_WIDTH-1:0] o_evtPc,
  output logic                  o_bpArmed,
  output logic [CYC_WIDTH-1:0]  o_cycles
);

  typedef enum logic [1:0] {
    ST_HALTED     = 2'd0,
    ST_RUN        = 2'd1,
    ST_STEP_CYC   = 2'd2,
    ST_STEP_INSTR = 2'd3
  } state_e;

  localparam logic [2:0] OP_HALT       = 3'd1;
  localparam logic [2:0] OP_RUN        = 3'd2;
  localparam logic [2:0] OP_STEP_CYC   = 3'd3;
  localparam logic [2:0] OP_STEP_INSTR = 3'd4;
  localparam logic [2:0] OP_SET_BP     = 3'd5;
  localparam logic [2:0] OP_CLR_BP     = 3'd6;
  localparam logic [2:0] OP_RSVD       = 3'd7;

  localparam logic [1:0] CAUSE_HOST  = 2'd0;
  localparam logic [1:0] CAUSE_STEP  = 2'd1;
  localparam logic [1:0] CAUSE_BREAK = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic                   halt_q, halt_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]  bp_addr_q, bp_addr_d;
  logic                   armed_q, armed_d;
  logic [ADDR_WIDTH-1:0]  last_pc_q, last_pc_d;
  logic                   evt_valid_q, evt_valid_d;
  logic [1:0]             evt_cause_q, evt_cause_d;
  logic [ADDR_WIDTH-1:0]  evt_pc_q, evt_pc_d;
  logic                   cmd_error_q, cmd_error_d;
  logic [CYC_WIDTH-1:0]   cycles_q, cycles_d;

  logic                   running;
  logic                   instr_seen;
  logic                   hit_break, hit_step, hit_host;
  logic [COUNT_WIDTH-1:0] cmd_count;
  logic [ADDR_WIDTH-1:0]  cmd_addr;

  assign cmd_count = cmd.i_cmdArg[COUNT_WIDTH-1:0];
  assign cmd_addr  = cmd.i_cmdArg[ADDR_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    bp_addr_d   = bp_addr_q;
    armed_d     = armed_q;
    last_pc_d   = last_pc_q;
    evt_valid_d = 1'b0;
    evt_cause_d = evt_cause_q;
    evt_pc_d    = evt_pc_q;
    cmd_error_d = 1'b0;

    running    = (state_q != ST_HALTED);
    instr_seen = running && i_instrFinished;
    cycles_d   = cycles_q + {{(CYC_WIDTH-1){1'b0}}, running};

    if (instr_seen) begin
      last_pc_d = i_pc;
    end

    // Halt sources are evaluated on the state as it stands before this edge.
    hit_break = instr_seen && armed_q && (i_pc == bp_addr_q);
    hit_step  = ((state_q == ST_STEP_CYC) && (rem_q == CNT_ONE)) ||
                ((state_q == ST_STEP_INSTR) && instr_seen && (rem_q == CNT_ONE));
    hit_host  = running && cmd.i_cmdValid && (cmd.i_cmdOp == OP_HALT);

    if (state_q == ST_STEP_CYC) begin
      rem_d = rem_q - CNT_ONE;
    end else if ((state_q == ST_STEP_INSTR) && instr_seen) begin
      rem_d = rem_q - CNT_ONE;
    end

    if (cmd.i_cmdValid) begin
      case (cmd.i_cmdOp)
        OP_SET_BP: begin
          bp_addr_d = cmd_addr;
          armed_d   = 1'b1;
        end
        OP_CLR_BP: armed_d = 1'b0;
        OP_RUN, OP_STEP_CYC, OP_STEP_INSTR: begin
          if (running) begin
            cmd_error_d = 1'b1;
          end else if (cmd.i_cmdOp == OP_RUN) begin
            state_d = ST_RUN;
          end else if (cmd_count != '0) begin
            rem_d   = cmd_count;
            state_d = (cmd.i_cmdOp == OP_STEP_CYC) ? ST_STEP_CYC : ST_STEP_INSTR;
          end
        end
        OP_RSVD: cmd_error_d = 1'b1;
        default: ;
      endcase
    end

    // Launch commands only act while halted and halt sources only while running,
    // so the two blocks above and below never compete for state_d.
    if (hit_break || hit_step || hit_host) begin
      state_d     = ST_HALTED;
      rem_d       = '0;
      evt_valid_d = 1'b1;
      evt_pc_d    = instr_seen ? i_pc : last_pc_q;
      if (hit_break) begin
        evt_cause_d = CAUSE_BREAK;
      end else if (hit_step) begin
        evt_cause_d = CAUSE_STEP;
      end else begin
        evt_cause_d = CAUSE_HOST;
      end
    end

    halt_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_HALTED;
      halt_q      <= 1'b1;
      rem_q       <= '0;
      bp_addr_q   <= '0;
      armed_q     <= 1'b0;
      last_pc_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_cause_q <= '0;
      evt_pc_q    <= '0;
      cmd_error_q <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      rem_q       <= rem_d;
      bp_addr_q   <= bp_addr_d;
      armed_q     <= armed_d;
      last_pc_q   <= last_pc_d;
      evt_valid_q <= evt_valid_d;
      evt_cause_q <= evt_cause_d;
      evt_pc_q    <= evt_pc_d;
      cmd_error_q <= cmd_error_d;
      cycles_q    <= cycles_d;
    end
  end

  assign cmd.o_cmdReady = 1'b1;
  assign cmd.o_cmdError = cmd_error_q;
  assign o_halt         = halt_q;
  assign o_state        = state_q;
  assign o_evtValid     = evt_valid_q;
  assign o_evtCause     = evt_cause_q;
  assign o_evtPc        = evt_pc_q;
  assign o_bpArmed      = armed_q;
  assign o_cycles       = cycles_q;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed and randomized checks of debug_run_ctrl against a transaction-level
// model of run/step/breakpoint behaviour.
module tb_debug_run_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_instrFinished = 1'b0;
  logic [15:0] i_pc = '0;
  logic        o_halt;
  logic [1:0]  o_state;
  logic        o_evtValid;
  logic [1:0]  o_evtCause;
  logic [15:0] o_evtPc;
  logic        o_bpArmed;
  logic [31:0] o_cycles;

  int n_cmp = 0;
  int n_err = 0;
  longint unsigned exp_cycles;

  always #5 i_clk = ~i_clk;

  debug_run_ctrl_if #(.ARG_WIDTH(16)) cmd_if ();

  debug_run_ctrl #(
    .ADDR_WIDTH(16), .COUNT_WIDTH(16), .CYC_WIDTH(32)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .cmd             (cmd_if),
    .i_instrFinished (i_instrFinished),
    .i_pc            (i_pc),
    .o_halt          (o_halt),
    .o_state         (o_state),
    .o_evtValid      (o_evtValid),
    .o_evtCause      (o_evtCause),
    .o_evtPc         (o_evtPc),
    .o_bpArmed       (o_bpArmed),
    .o_cycles        (o_cycles)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] arg);
    cmd_if.i_cmdValid = 1'b1;
    cmd_if.i_cmdOp    = op;
    cmd_if.i_cmdArg   = arg;
    step();
    cmd_if.i_cmdValid = 1'b0;
    cmd_if.i_cmdOp    = 3'd0;
    cmd_if.i_cmdArg   = '0;
  endtask

  task automatic pulse(input logic [15:0] pc);
    i_instrFinished = 1'b1;
    i_pc            = pc;
    step();
    i_instrFinished = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Counts cycles with o_halt low; the bound keeps a stuck DUT from hanging the run.
  task automatic count_low(output int n);
    n = 0;
    while (o_halt === 1'b0 && n < 2000) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n, cnt, idx, run_cyc;
    logic armed;
    logic [15:0] bp;
    logic [1:0] cause;
    logic [15:0] pcs [5];
    int gaps [5];

    cmd_if.i_cmdValid = 1'b0;
    cmd_if.i_cmdOp    = 3'd0;
    cmd_if.i_cmdArg   = '0;

    // Reset state
    idle(2);
    i_reset = 1'b0;
    chk("rst_halt", o_halt, 1);
    chk("rst_state", o_state, 0);
    chk("rst_cycles", o_cycles, 0);
    chk("rst_armed", o_bpArmed, 0);
    chk("rst_evt", o_evtValid, 0);
    chk("rst_ready", cmd_if.o_cmdReady, 1);

    // STEP_CYC 5
    send(3'd3, 16'd5);
    count_low(cnt);
    chk("stepcyc_low", cnt, 5);
    chk("stepcyc_evt", o_evtValid, 1);
    chk("stepcyc_cause", o_evtCause, 1);
    chk("stepcyc_cycles", o_cycles, 5);
    step();
    chk("stepcyc_evt_pulse", o_evtValid, 0);

    // STEP_INSTR 3 with pulses every 4 cycles
    send(3'd4, 16'd3);
    for (int j = 0; j < 3; j++) begin
      idle(3);
      chk("stepi_running", o_halt, 0);
      pulse(16'h0010 + 16'(j));
    end
    chk("stepi_halt", o_halt, 1);
    chk("stepi_evt", o_evtValid, 1);
    chk("stepi_cause", o_evtCause, 1);
    chk("stepi_pc", o_evtPc, 16'h0012);

    // Breakpoint on RUN, then resume past it
    send(3'd5, 16'h0040);
    chk("setbp_armed", o_bpArmed, 1);
    chk("setbp_halt", o_halt, 1);
    send(3'd2, 16'd0);
    chk("run_state", o_state, 1);
    idle(2);
    pulse(16'h0040);
    chk("bp_halt", o_halt, 1);
    chk("bp_evt", o_evtValid, 1);
    chk("bp_cause", o_evtCause, 2);
    chk("bp_pc", o_evtPc, 16'h0040);
    send(3'd2, 16'd0);
    pulse(16'h0041);
    chk("bp_nomatch_halt", o_halt, 0);
    chk("bp_nomatch_evt", o_evtValid, 0);
    idle(3);
    chk("bp_still_run", o_halt, 0);
    send(3'd1, 16'd0);
    chk("host_halt", o_halt, 1);
    chk("host_evt", o_evtValid, 1);
    chk("host_cause", o_evtCause, 0);
    chk("host_pc", o_evtPc, 16'h0041);

    // STEP_INSTR 1 coinciding with a breakpoint match
    send(3'd4, 16'd1);
    pulse(16'h0040);
    chk("both_evt", o_evtValid, 1);
    chk("both_cause", o_evtCause, 2);
    step();
    chk("both_single", o_evtValid, 0);

    // Command errors and no-ops
    send(3'd2, 16'd0);
    send(3'd2, 16'd0);
    chk("rerun_err", cmd_if.o_cmdError, 1);
    chk("rerun_state", o_state, 1);
    step();
    chk("rerun_err_pulse", cmd_if.o_cmdError, 0);
    chk("rerun_still", o_state, 1);
    send(3'd1, 16'd0);
    chk("halt_evt", o_evtValid, 1);
    chk("halt_cause", o_evtCause, 0);
    send(3'd1, 16'd0);
    chk("halt2_evt", o_evtValid, 0);
    chk("halt2_err", cmd_if.o_cmdError, 0);
    send(3'd3, 16'd0);
    chk("step0_state", o_state, 0);
    chk("step0_evt", o_evtValid, 0);
    chk("step0_err", cmd_if.o_cmdError, 0);
    send(3'd7, 16'd0);
    chk("op7_err", cmd_if.o_cmdError, 1);
    send(3'd6, 16'd0);
    chk("clrbp_armed", o_bpArmed, 0);

    // Reset mid-step; a command presented during reset is dropped
    send(3'd5, 16'h1234);
    send(3'd3, 16'd10);
    idle(2);
    i_reset = 1'b1;
    cmd_if.i_cmdValid = 1'b1;
    cmd_if.i_cmdOp    = 3'd2;
    step();
    i_reset = 1'b0;
    cmd_if.i_cmdValid = 1'b0;
    cmd_if.i_cmdOp    = 3'd0;
    chk("mrst_halt", o_halt, 1);
    chk("mrst_evt", o_evtValid, 0);
    chk("mrst_cycles", o_cycles, 0);
    chk("mrst_armed", o_bpArmed, 0);
    chk("mrst_cause", o_evtCause, 0);
    chk("mrst_pc", o_evtPc, 0);
    step();
    chk("mrst_dropped", o_state, 0);
    chk("mrst_noevt", o_evtValid, 0);

    // Randomized steps against the transaction model
    exp_cycles = 0;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 12);
        send(3'd3, 16'(n));
        count_low(cnt);
        exp_cycles += longint'(n);
        chk("rnd_cyc_low", cnt, n);
        chk("rnd_cyc_cause", o_evtCause, 1);
        chk("rnd_cyc_evt", o_evtValid, 1);
        chk("rnd_cyc_cycles", o_cycles, exp_cycles[31:0]);
      end else begin
        n     = $urandom_range(1, 5);
        armed = 1'($urandom_range(0, 1));
        bp    = 16'h0100 + 16'($urandom_range(0, 7));
        for (int i = 0; i < 5; i++) begin
          pcs[i]  = 16'h0100 + 16'($urandom_range(0, 7));
          gaps[i] = $urandom_range(0, 3);
        end
        if (armed) send(3'd5, bp);
        else       send(3'd6, 16'd0);
        idx = n - 1;
        cause = 2'd1;
        for (int i = 0; i < n; i++) begin
          if (armed && pcs[i] == bp) begin
            idx = i;
            cause = 2'd2;
            break;
          end
        end
        run_cyc = 0;
        for (int i = 0; i <= idx; i++) run_cyc += gaps[i] + 1;
        exp_cycles += longint'(run_cyc);
        send(3'd4, 16'(n));
        for (int i = 0; i <= idx; i++) begin
          idle(gaps[i]);
          pulse(pcs[i]);
          if (i < idx) chk("rnd_instr_run", o_halt, 0);
        end
        chk("rnd_instr_halt", o_halt, 1);
        chk("rnd_instr_evt", o_evtValid, 1);
        chk("rnd_instr_cause", o_evtCause, cause);
        chk("rnd_instr_pc", o_evtPc, pcs[idx]);
        chk("rnd_instr_cycles", o_cycles, exp_cycles[31:0]);
      end
      step();
      chk("rnd_evt_pulse", o_evtValid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debug_run_ctrl.md
# debug_run_ctrl

Host-facing run/step/breakpoint controller for the CPU clock-gating path. It accepts debug commands from the host link and drives a single registered halt line that freezes CPU clock advance. Supported commands: free run, N-cycle step, N-instruction step, breakpoint arm/clear. It reports every halt caused by a run or step with a cause code and the PC at the halt.

## Interface

Parameters:

- ADDR_WIDTH, 16, width of PC and breakpoint address
- COUNT_WIDTH, 16, width of step count argument
- CYC_WIDTH, 32, width of executed-cycle counter

Ports. One clock; reset is synchronous and active-high.

- i_clk  in  1  system clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_cmdValid  in  1  command present
- i_cmdOp  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP_CYC, 4 STEP_INSTR, 5 SET_BP, 6 CLR_BP, 7 reserved
- i_cmdArg  in  max(ADDR_WIDTH,COUNT_WIDTH)  step count or breakpoint address, LSB-aligned
- o_cmdReady  out  1  constant 1; command is accepted on any cycle with i_cmdValid=1
- o_cmdError  out  1  one-cycle pulse: command rejected
- i_instrFinished  in  1  one-cycle pulse from control: instruction completed this cycle
- i_pc  in  ADDR_WIDTH  PC of the next instruction, valid when i_instrFinished=1
- o_halt  out  1  1 = CPU frozen; registered
- o_state  out  2  0 HALTED, 1 RUN, 2 STEP_CYC, 3 STEP_INSTR
- o_evtValid  out  1  one-cycle pulse: transition into HALTED
- o_evtCause  out  2  0 HOST_HALT, 1 STEP_DONE, 2 BREAK; held until next event
- o_evtPc  out  ADDR_WIDTH  last i_pc sampled with i_instrFinished=1; captured when the event fires
- o_bpArmed  out  1  breakpoint enabled
- o_cycles  out  CYC_WIDTH  count of cycles with o_halt=0; wraps modulo 2^CYC_WIDTH

## Operation

- FSM states: HALTED, RUN, STEP_CYC, STEP_INSTR. Output o_halt = (state == HALTED).
- In HALTED:
  - RUN enters RUN.
  - STEP_CYC with N>0 loads remCnt=N and enters STEP_CYC.
  - STEP_INSTR with N>0 loads remCnt=N and enters STEP_INSTR.
  - N=0 is a silent no-op: no state change, no event, no error.
- RUN, STEP_CYC or STEP_INSTR issued while not HALTED: o_cmdError pulse, command has no effect.
- Op 7: o_cmdError pulse, no effect.
- SET_BP: bpAddr=arg, armed=1. CLR_BP: armed=0. Both are legal in any state and never raise an error.
- HALT in a running state: enter HALTED, remCnt discarded, cause HOST_HALT. HALT in HALTED: no event, no error.
- STEP_CYC: remCnt decrements every cycle; at remCnt==1 enter HALTED, cause STEP_DONE.
- STEP_INSTR: remCnt decrements on each i_instrFinished; when i_instrFinished=1 and remCnt==1, enter HALTED, cause STEP_DONE.
- Breakpoint hit: in any running state with armed=1, i_instrFinished=1 and i_pc==bpAddr, enter HALTED, cause BREAK.
- If several halt causes hit on the same edge, exactly one event fires. Cause priority is BREAK > STEP_DONE > HOST_HALT.
- i_instrFinished and i_pc are ignored while HALTED.
- Resuming from a breakpoint does not re-trigger it: the next match needs a later i_instrFinished with i_pc==bpAddr.

## Timing

- Command accepted at edge k: effect (state, o_halt, bp regs) is visible after edge k; o_cmdError is high in cycle k+1 only.
- RUN accepted at edge k: o_halt=0 from cycle k+1.
- STEP_CYC N accepted at edge k: o_halt=0 for exactly N cycles (k+1 .. k+N). o_halt=1 and o_evtValid=1 in cycle k+N+1. o_cycles increases by exactly N.
- Halt condition sampled at edge e (break, instruction step, or HALT command): o_halt=1 and o_evtValid=1 in cycle e+1. The CPU cycle ending at edge e has already executed.
- o_cycles increments at each edge where o_halt=0 was observed.
- Reset, applied at any time including mid-step:
  - state HALTED, o_halt=1
  - remCnt=0, bpAddr=0, armed=0
  - o_cycles=0, o_evtCause=0, o_evtPc=0
  - o_evtValid=0, o_cmdError=0
  - no event is emitted for the aborted step
- Commands presented with i_reset=1 are dropped.

## Test plan

- Reset then STEP_CYC arg=5 → o_halt low exactly 5 cycles; evtValid pulse with cause=1; o_cycles=5.
- STEP_INSTR arg=3, i_instrFinished pulses every 4 cycles with PCs 0x10, 0x11, 0x12 → halt the cycle after the 3rd pulse; cause=1; evtPc=0x12.
- SET_BP 0x0040, RUN, instrFinished with pc=0x0040 → halt next cycle; cause=2; evtPc=0x0040. Then RUN again with pc sequence 0x41 → no halt.
- STEP_INSTR arg=1 with breakpoint matching on the same finishing pulse → single evtValid pulse; cause=2.
- RUN then RUN → cmdError pulse, stays RUN; HALT → cause=0. HALT again → no event. STEP_CYC arg=0 → no change. Op 7 → cmdError pulse.
- i_reset asserted on cycle 3 of STEP_CYC arg=10 → o_halt=1 next cycle, no event, o_cycles=0, o_bpArmed=0.
